// File: rtl/game_ctrl.sv
// Frame-rate game sequencer: collision capture, frame-rate button edge detection
// and the TITLE/PLAY/HIT/PAUSE/OVER state machine that configures the sprite modules.
module game_ctrl #(
    parameter int unsigned HIT_FRAMES = 60,
    parameter int unsigned LIVES      = 3,
    parameter int unsigned SPEED_INIT = 1,
    parameter int unsigned SPEED_MAX  = 7,
    parameter int unsigned SPEED_STEP = 10
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_v_sync,
    input  logic       i_active,
    input  logic       i_btn1,
    input  logic       i_btn2,
    input  logic       i_btn3,
    input  logic       i_penguin_hit,
    input  logic       i_glacier1_hit,
    input  logic       i_glacier2_hit,
    input  logic       i_coin_hit,
    output logic [2:0] o_state,
    output logic       o_run,
    output logic [2:0] o_speed,
    output logic [7:0] o_score,
    output logic [1:0] o_lives,
    output logic       o_blink,
    output logic       o_jump,
    output logic       o_coin_respawn
);

    typedef enum logic [2:0] {
        S_TITLE = 3'd0,
        S_PLAY  = 3'd1,
        S_HIT   = 3'd2,
        S_PAUSE = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_vs_d;
    logic [2:0] r_btn_s0;
    logic [2:0] r_btn_s1;
    logic [2:0] r_btn_now;
    logic [2:0] r_btn_prev;
    logic       r_gcol;
    logic       r_ccol;
    logic [7:0] r_timer;
    logic [7:0] r_step;
    logic [2:0] r_speed;
    logic [7:0] r_score;
    logic [1:0] r_lives;
    logic       r_run;
    logic       r_blink;
    logic       r_jump;
    logic       r_resp;

    logic       w_tick;
    logic [2:0] w_press;
    logic       w_gpix;
    logic       w_cpix;
    logic       w_coin;
    logic [7:0] w_timer_nxt;
    logic [7:0] w_step_nxt;
    logic [2:0] w_speed_nxt;
    logic [7:0] w_score_nxt;
    logic [1:0] w_lives_nxt;
    logic       w_jump_nxt;
    logic       w_resp_nxt;

    assign w_tick  = i_v_sync & ~r_vs_d;
    assign w_press = r_btn_now & ~r_btn_prev;
    assign w_gpix  = i_active & i_penguin_hit & (i_glacier1_hit | i_glacier2_hit);
    assign w_cpix  = i_active & i_penguin_hit & i_coin_hit;

    // Input pipeline: frame tick, button synchronisers, per-frame collision flags.
    // The flags reload with the tick cycle's pixel so that pixel counts next frame.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vs_d     <= 1'b0;
            r_btn_s0   <= 3'b000;
            r_btn_s1   <= 3'b000;
            r_btn_now  <= 3'b000;
            r_btn_prev <= 3'b000;
            r_gcol     <= 1'b0;
            r_ccol     <= 1'b0;
        end else begin
            r_vs_d   <= i_v_sync;
            r_btn_s0 <= {i_btn3, i_btn2, i_btn1};
            r_btn_s1 <= r_btn_s0;
            if (w_tick) begin
                r_btn_now  <= r_btn_s1;
                r_btn_prev <= r_btn_now;
                r_gcol     <= w_gpix;
                r_ccol     <= w_cpix;
            end else begin
                r_gcol <= r_gcol | w_gpix;
                r_ccol <= r_ccol | w_cpix;
            end
        end
    end

    // State and game-variable registers; outputs follow the next-state values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_TITLE;
            r_timer <= 8'd0;
            r_step  <= 8'd0;
            r_speed <= 3'(SPEED_INIT);
            r_score <= 8'd0;
            r_lives <= 2'(LIVES);
            r_run   <= 1'b0;
            r_blink <= 1'b0;
            r_jump  <= 1'b0;
            r_resp  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_step  <= w_step_nxt;
            r_speed <= w_speed_nxt;
            r_score <= w_score_nxt;
            r_lives <= w_lives_nxt;
            r_run   <= (w_state_nxt == S_PLAY) || (w_state_nxt == S_HIT);
            r_blink <= (w_state_nxt == S_HIT) & w_timer_nxt[3];
            r_jump  <= w_jump_nxt;
            r_resp  <= w_resp_nxt;
        end
    end

    // Next-state logic; everything is held except on the frame tick.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_step_nxt  = r_step;
        w_speed_nxt = r_speed;
        w_score_nxt = r_score;
        w_lives_nxt = r_lives;
        w_jump_nxt  = 1'b0;
        w_resp_nxt  = 1'b0;
        w_coin      = 1'b0;
        if (w_tick) begin
            if (w_press[2]) begin
                w_state_nxt = S_TITLE;
            end else begin
                case (r_state)
                    S_TITLE: begin
                        if (w_press[0]) begin
                            w_state_nxt = S_PLAY;
                            w_score_nxt = 8'd0;
                            w_lives_nxt = 2'(LIVES);
                            w_speed_nxt = 3'(SPEED_INIT);
                            w_step_nxt  = 8'd0;
                            w_resp_nxt  = 1'b1;
                        end
                    end
                    S_PLAY: begin
                        if (r_gcol) begin
                            if (r_lives <= 2'd1) begin
                                w_lives_nxt = 2'd0;
                                w_state_nxt = S_OVER;
                            end else begin
                                w_lives_nxt = r_lives - 2'd1;
                                w_state_nxt = S_HIT;
                                w_timer_nxt = 8'(HIT_FRAMES);
                            end
                        end else begin
                            w_coin     = r_ccol;
                            w_jump_nxt = w_press[1];
                            if (!r_ccol && w_press[0]) begin
                                w_state_nxt = S_PAUSE;
                            end
                        end
                    end
                    S_HIT: begin
                        w_coin     = r_ccol;
                        w_jump_nxt = w_press[1];
                        if (r_timer <= 8'd1) begin
                            w_timer_nxt = 8'd0;
                            w_state_nxt = S_PLAY;
                        end else begin
                            w_timer_nxt = r_timer - 8'd1;
                        end
                    end
                    S_PAUSE: begin
                        if (w_press[0]) begin
                            w_state_nxt = S_PLAY;
                        end
                    end
                    S_OVER: begin
                        if (w_press[0]) begin
                            w_state_nxt = S_TITLE;
                        end
                    end
                    default: begin
                        w_state_nxt = S_TITLE;
                    end
                endcase
            end
        end
        // Coin pickup: saturating score, speed bumps every SPEED_STEP coins.
        if (w_coin) begin
            w_resp_nxt = 1'b1;
            if (r_score != 8'hFF) begin
                w_score_nxt = r_score + 8'd1;
            end
            if (r_step >= 8'(SPEED_STEP - 1)) begin
                w_step_nxt = 8'd0;
                if (r_speed < 3'(SPEED_MAX)) begin
                    w_speed_nxt = r_speed + 3'd1;
                end
            end else begin
                w_step_nxt = r_step + 8'd1;
            end
        end
    end

    assign o_state        = r_state;
    assign o_run          = r_run;
    assign o_speed        = r_speed;
    assign o_score        = r_score;
    assign o_lives        = r_lives;
    assign o_blink        = r_blink;
    assign o_jump         = r_jump;
    assign o_coin_respawn = r_resp;

endmodule
